// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types, mode encodings and the LED pattern generator for led_seq_driver.
package led_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE_ST} state_e;
  localparam logic [1:0] MODE_WALK_L = 2'b00;
  localparam logic [1:0] MODE_WALK_R = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;
  // Active-high pattern for a step; callers pass the step modulo 16.
  function automatic logic [3:0] pattern(input logic [1:0] mode, input logic [3:0] step);
    return mode == MODE_WALK_L ? 4'b0001 << step[1:0] :
           mode == MODE_WALK_R ? 4'b1000 >> step[1:0] :
           mode == MODE_BLINK  ? {4{~step[0]}} : step;
  endfunction
endpackage

// File: rtl/led_seq_driver_start_sync_edge.sv
// start_sync_edge: 2-flop synchronizer plus registered rising-edge pulse for an asynchronous input.
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   async_i in  asynchronous level
//   edge_o  out one-cycle pulse, valid on the 3rd rising edge after async_i rises
module start_sync_edge #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);
  logic meta_q, sync_q, prev_q, edge_q;
  // Resetting to RST_VAL=1 means a level already high at reset release is not an edge;
  // the input must be seen low before a rising edge is reported.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
      prev_q <= RST_VAL;
      edge_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      edge_q <= sync_q & ~prev_q;
    end
  end
  assign edge_o = edge_q;
endmodule

// File: rtl/led_seq_driver.sv
// led_seq_driver: launches a timed 4-LED pattern sequence on a START rising edge.
//   clk               in  system clock
//   rst_n             in  asynchronous active-low reset
//   start_i           in  asynchronous sequence request (rising edge)
//   abort_i           in  synchronous cancel of a running sequence
//   mode_i[1:0]       in  pattern select, latched at start
//   led1_o..led4_o    out board LEDs (led1_o = pattern bit 0), inverted when ACTIVE_LOW_LED
//   busy_o            out high while a sequence runs
//   done_o            out one-cycle pulse on normal completion
module led_seq_driver
  import led_seq_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int STEP_HZ        = 4,
  parameter int NUM_STEPS      = 8,
  parameter int ACTIVE_LOW_LED = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic [1:0] mode_i,
  output logic       led1_o,
  output logic       led2_o,
  output logic       led3_o,
  output logic       led4_o,
  output logic       busy_o,
  output logic       done_o
);
  localparam int   DIV = CLK_HZ / STEP_HZ;
  localparam int   PW  = DIV > 1 ? $clog2(DIV) : 1;
  localparam int   SW  = $clog2(NUM_STEPS + 1);
  localparam logic AL  = ACTIVE_LOW_LED != 0;
  if (DIV < 1 || NUM_STEPS < 1) begin : g_bad_params
    $error("led_seq_driver: CLK_HZ/STEP_HZ and NUM_STEPS must both be >= 1");
  end
  state_e          state_q, state_d;
  logic [1:0]      mode_q, mode_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [SW-1:0]   step_q, step_d;
  logic [3:0]      led_q, led_d;
  logic            busy_q, done_q, start_edge;
  start_sync_edge #(.RST_VAL(1'b1)) u_start (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(start_i),
    .edge_o (start_edge)
  );
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    step_d  = step_q;
    case (state_q)
      IDLE: if (start_edge && !abort_i) begin
        state_d = RUN;
        mode_d  = mode_i;
        presc_d = '0;
        step_d  = '0;
      end
      RUN: if (abort_i) state_d = IDLE;
      else if (presc_q == PW'(DIV - 1)) begin
        presc_d = '0;
        if (step_q == SW'(NUM_STEPS - 1)) state_d = DONE_ST;
        else step_d = step_q + 1'b1;
      end else presc_d = presc_q + 1'b1;
      default: state_d = IDLE;
    endcase
    // Outputs are computed from next state so every output pin comes straight off a flop.
    led_d = (state_d == RUN ? pattern(mode_d, 4'(step_d)) : 4'b0000) ^ {4{AL}};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_WALK_L;
      presc_q <= '0;
      step_q  <= '0;
      led_q   <= {4{AL}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      presc_q <= presc_d;
      step_q  <= step_d;
      led_q   <= led_d;
      busy_q  <= state_d == RUN;
      done_q  <= state_d == DONE_ST;
    end
  end
  assign {led4_o, led3_o, led2_o, led1_o} = led_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

// File: tb/tb_led_seq_driver.sv
// tb_led_seq_driver: scoreboard bench for led_seq_driver with DIV=4, NUM_STEPS=4, active-low LEDs.
module tb_led_seq_driver;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_i = 1'b0;
  logic       abort_i = 1'b0;
  logic [1:0] mode_i = 2'b00;
  logic       led1_o, led2_o, led3_o, led4_o, busy_o, done_o;
  int         n_vec = 0;
  int         n_err = 0;
  logic [5:0] exp_q[$];
  logic [3:0] pat_tab [4][4];
  localparam logic [5:0] DARK = 6'b00_1111;

  led_seq_driver #(.CLK_HZ(8), .STEP_HZ(2), .NUM_STEPS(4), .ACTIVE_LOW_LED(1)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(start_i),
    .abort_i(abort_i),
    .mode_i (mode_i),
    .led1_o (led1_o),
    .led2_o (led2_o),
    .led3_o (led3_o),
    .led4_o (led4_o),
    .busy_o (busy_o),
    .done_o (done_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {busy_o, done_o, led4_o, led3_o, led2_o, led1_o};
  endfunction

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk("out", 32'(outs()), 32'(exp_q.pop_front()));
  end

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(DARK);
  endtask

  task automatic push_run(input int m, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({2'b10, ~pat_tab[m][(k / 4) % 4]});
  endtask

  task automatic push_done();
    exp_q.push_back(6'b01_1111);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic full_run(input logic [1:0] m, input int change_at, input logic [1:0] m2);
    @(negedge clk);
    mode_i = m;
    start_i = 1'b1;
    push_idle(3);
    push_run(int'(m), 16);
    push_done();
    push_idle(2);
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    if (change_at > 0) begin
      repeat (change_at) @(negedge clk);
      mode_i = m2;
    end
    drain();
  endtask

  initial begin
    pat_tab[0] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    pat_tab[1] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
    pat_tab[2] = '{4'b1111, 4'b0000, 4'b1111, 4'b0000};
    pat_tab[3] = '{4'b0000, 4'b0001, 4'b0010, 4'b0011};
    #1 rst_n = 1'b0;
    #1 chk("reset0", 32'(outs()), 32'(DARK));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // walk-left, then blink with a MODE change mid-run, then count
    full_run(2'b00, 0, 2'b00);
    full_run(2'b10, 7, 2'b11);
    full_run(2'b11, 0, 2'b11);
    // re-trigger at RUN cycle 6 is ignored, ABORT at RUN cycle 9 goes dark with no DONE
    @(negedge clk);
    mode_i = 2'b00;
    start_i = 1'b1;
    push_idle(3);
    push_run(0, 10);
    push_idle(6);
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    repeat (8) @(negedge clk);
    start_i = 1'b1;
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    drain();
    // START held for 40 cycles gives one sequence; a fresh edge (walk-right) gives another
    @(negedge clk);
    mode_i = 2'b01;
    start_i = 1'b1;
    push_idle(3);
    push_run(1, 16);
    push_done();
    push_idle(25);
    repeat (40) @(negedge clk);
    start_i = 1'b0;
    drain();
    full_run(2'b01, 0, 2'b01);
    // async reset at RUN cycle 7 with START held; release must not start a sequence
    @(negedge clk);
    mode_i = 2'b11;
    start_i = 1'b1;
    push_idle(3);
    push_run(3, 8);
    repeat (11) @(negedge clk);
    chk("pre_rst_q", 32'(exp_q.size()), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid", 32'(outs()), 32'(DARK));
    @(negedge clk);
    rst_n = 1'b1;
    push_idle(20);
    drain();
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    full_run(2'b00, 0, 2'b00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
